// File: rtl/dmux16_stream.sv
// dmux16_stream: routes 16-bit words from one valid/ready stream to channel
// A or channel B according to in_sel. Each channel is buffered by its own
// DEPTH-entry FIFO, so a stalled consumer never blocks the other channel.
// Optional macro DMUX16_STREAM_COUNT_EN adds per-channel popped-word
// counters (a_count, b_count).
`timescale 1ns/1ps

module dmux16_stream #(
    parameter int DEPTH = 2            // 2, 4 or 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] a_data,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [15:0] b_data,
    output logic        b_valid,
    input  logic        b_ready
`ifdef DMUX16_STREAM_COUNT_EN
    ,
    output logic [15:0] a_count,
    output logic [15:0] b_count
`endif
);

    localparam int PW = $clog2(DEPTH);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0]  push;
    logic [1:0]  pop;
    logic [1:0]  full;
    logic [1:0]  nonempty;
    logic [1:0]  out_ready;
    logic [15:0] head [2];

    assign out_ready = {b_ready, a_ready};

    // Acceptance depends only on the selection and registered occupancy; a
    // full channel refuses even when it is popped this cycle.
    assign in_ready = (in_sel ? !full[1] : !full[0]) && !reset;

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [15:0]   mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [PW:0]   count;

        assign full[c]     = (count == (PW+1)'(DEPTH));
        assign nonempty[c] = (count != '0);
        assign push[c]     = in_valid && in_ready && (in_sel == 1'(c));
        assign pop[c]      = nonempty[c] && out_ready[c] && !reset;
        assign head[c]     = nonempty[c] ? mem[rd_ptr] : 16'h0000;

        // Pointers wrap naturally at DEPTH (a power of two); count tracks occupancy.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[c]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[c])  rd_ptr <= rd_ptr + PW'(1);
                if (push[c] && !pop[c])      count <= count + (PW+1)'(1);
                else if (pop[c] && !push[c]) count <= count - (PW+1)'(1);
            end
        end

        // Storage write at the tail.
        always_ff @(posedge clk) begin
            // NOTE: storage is deliberately not reset; head output is gated by
            // occupancy, so stale contents are never visible.
            if (push[c]) mem[wr_ptr] <= in_data;
        end
    end

    assign a_data  = head[0];
    assign b_data  = head[1];
    assign a_valid = nonempty[0];
    assign b_valid = nonempty[1];

`ifdef DMUX16_STREAM_COUNT_EN
    // Popped-word counters, visible the cycle after the pop; wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_count <= 16'h0000;
            b_count <= 16'h0000;
        end else begin
            if (pop[0]) a_count <= a_count + 16'h0001;
            if (pop[1]) b_count <= b_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_dmux16_stream.sv
// Testbench for dmux16_stream: directed stimulus feeds per-channel expected
// queues; a negedge monitor pops and compares on every consumer handshake.
`timescale 1ns/1ps

module tb_dmux16_stream;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DMUX16_STREAM_COUNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    dmux16_stream #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DMUX16_STREAM_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; record it as expected once the DUT shows in_ready.
    task automatic send(input logic [15:0] d, input logic s, output int waits);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (s) qb.push_back(d);
                else   qa.push_back(d);
                break;
            end
            waits++;
            if (waits > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: word %h sel %0d not accepted in 20 cycles", d, s);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every consumer handshake must deliver the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_pop: got %h expected no word", a_data);
                end else begin
                    check("a_pop", 32'(a_data), 32'(qa.pop_front()));
                end
            end
            if (!reset && b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_pop: got %h expected no word", b_data);
                end else begin
                    check("b_pop", 32'(b_data), 32'(qb.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset    = 1'b1;
        in_data  = 16'h0000;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset held two cycles.
        tick();
        check("in_ready_in_reset", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_a_data", 32'(a_data), 32'h0);
        check("rst_b_data", 32'(b_data), 32'h0);
        in_sel = 1'b0; #1;
        check("rst_in_ready_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1; #1;
        check("rst_in_ready_sel1", 32'(in_ready), 32'd1);

        // One word to each channel, consumers ready.
        a_ready = 1'b1;
        b_ready = 1'b1;
        send(16'h1234, 1'b0, w);
        check("a_first_wait", 32'(w), 32'd0);
        check("a_latency_valid", 32'(a_valid), 32'd1);
        check("a_latency_data", 32'(a_data), 32'h1234);
        send(16'hABCD, 1'b1, w);
        check("a_single_cycle", 32'(a_valid), 32'd0);
        check("b_latency_valid", 32'(b_valid), 32'd1);
        check("b_latency_data", 32'(b_data), 32'hABCD);
        tick();
        check("b_single_cycle", 32'(b_valid), 32'd0);
        check("b_empty_data", 32'(b_data), 32'h0);

        // Fill A with consumer stalled; third word must wait.
        a_ready = 1'b0;
        send(16'h0001, 1'b0, w);
        send(16'h0002, 1'b0, w);
        in_data  = 16'h0003;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("a_full_in_ready", 32'(in_ready), 32'd0);
        check("a_full_head", 32'(a_data), 32'h0001);
        tick();
        a_ready = 1'b1;
        @(negedge clk);
        check("a_full_no_passthru", 32'(in_ready), 32'd0);
        tick();
        a_ready = 1'b0;
        #1;
        check("a_after_pulse_head", 32'(a_data), 32'h0002);
        send(16'h0003, 1'b0, w);
        check("a_third_wait", 32'(w), 32'd0);

        // A full and stalled: B still accepts at once.
        b_ready = 1'b0;
        send(16'h00FF, 1'b1, w);
        check("b_while_a_full_wait", 32'(w), 32'd0);
        check("b_while_a_full_valid", 32'(b_valid), 32'd1);
        check("b_while_a_full_data", 32'(b_data), 32'h00FF);
        check("a_stalled_head", 32'(a_data), 32'h0002);

        // Reset with A=2 words, B=1 word discards everything.
        reset   = 1'b1;
        qa.delete();
        qb.delete();
        a_ready = 1'b1;
        b_ready = 1'b1;
        #1;
        check("in_ready_reset_mid", 32'(in_ready), 32'd0);
        tick();
        check("flush_a_valid", 32'(a_valid), 32'd0);
        check("flush_b_valid", 32'(b_valid), 32'd0);
        check("flush_a_data", 32'(a_data), 32'h0);
        check("flush_b_data", 32'(b_data), 32'h0);
        reset = 1'b0;
        send(16'h5555, 1'b0, w);
        check("post_flush_data", 32'(a_data), 32'h5555);
        tick();
        check("post_flush_alone", 32'(a_valid), 32'd0);

        // B full and stalled; selection flip re-evaluates in_ready.
        b_ready = 1'b0;
        send(16'h0B01, 1'b1, w);
        send(16'h0B02, 1'b1, w);
        in_data  = 16'h0A01;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        #1;
        check("b_full_in_ready", 32'(in_ready), 32'd0);
        in_sel = 1'b0;
        #1;
        check("sel_flip_in_ready", 32'(in_ready), 32'd1);
        send(16'h0A01, 1'b0, w);
        check("a_past_stalled_b", 32'(w), 32'd0);
        b_ready = 1'b1;
        repeat (3) tick();
        check("b_drained", 32'(b_valid), 32'd0);

        // Sustained one word per cycle to A; pointers wrap several times.
        a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(16'h7000 + 16'(i), 1'b0, w);
            check("a_throughput_wait", 32'(w), 32'd0);
        end
        repeat (3) tick();
        check("a_drained", 32'(a_valid), 32'd0);

`ifdef DMUX16_STREAM_COUNT_EN
        // Counter wrap on A; B untouched.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt_rst_a", 32'(a_count), 32'h0);
        check("cnt_rst_b", 32'(b_count), 32'h0);
        a_ready = 1'b1;
        for (int i = 0; i < 65534; i++) send(16'(i), 1'b0, w);
        tick();
        check("cnt_a_fffe", 32'(a_count), 32'hFFFE);
        send(16'hC001, 1'b0, w);
        tick();
        check("cnt_a_ffff", 32'(a_count), 32'hFFFF);
        send(16'hC002, 1'b0, w);
        tick();
        check("cnt_a_wrap", 32'(a_count), 32'h0000);
        check("cnt_b_unchanged", 32'(b_count), 32'h0000);
`endif

        repeat (3) tick();
        check("qa_all_delivered", 32'(qa.size()), 32'd0);
        check("qb_all_delivered", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
